// File: rtl/entrada_teclado.sv
// entrada_teclado: key-entry conditioner in front of the combination-lock FSM.
// Synchronises and debounces a raw confirm button, range-checks the 4-bit digit
// and emits one clean insere (digit 0-9) or erro (digit 10-15) strobe per press.
// Optional macro ENTRADA_AUTOREPEAT_EN: a held key re-issues a strobe every
// REPEAT_CYCLES cycles while it stays pressed.
module entrada_teclado #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botao,
  input  logic [4:1] chave,
  output logic [4:1] numero,
  output logic       insere,
  output logic       erro,
  output logic       ocupado
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  logic       botao_m, botao_s;
  logic [4:1] chave_m, chave_s;
  state_t     state;
  logic [CW-1:0] cnt;
  logic       digit_ok;

`ifdef ENTRADA_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt;
`endif

  // digit sampled at acceptance time must be decimal
  assign digit_ok = (chave_s <= 4'd9);

  // busy whenever the registered state has left IDLE
  assign ocupado = (state != IDLE);

  // two-stage synchronisers for the asynchronous button and switch bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      botao_m <= 1'b0;
      botao_s <= 1'b0;
      chave_m <= '0;
      chave_s <= '0;
    end else begin
      botao_m <= botao;
      botao_s <= botao_m;
      chave_m <= chave;
      chave_s <= chave_m;
    end
  end

  // debounce FSM with registered digit and single-cycle strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      numero <= '0;
      insere <= 1'b0;
      erro   <= 1'b0;
`ifdef ENTRADA_AUTOREPEAT_EN
      rcnt   <= '0;
`endif
    end else begin
      insere <= 1'b0;
      erro   <= 1'b0;
      case (state)
        IDLE: begin
          if (botao_s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!botao_s) begin
            // bounce: back to idle without a strobe
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= PRESSED;
            cnt   <= '0;
            if (digit_ok) begin
              numero <= chave_s;
              insere <= 1'b1;
            end else begin
              erro   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!botao_s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
`ifdef ENTRADA_AUTOREPEAT_EN
            rcnt  <= '0;
          end else if (rcnt == REP_MAX) begin
            // held key: re-sample the digit and strobe again
            rcnt <= '0;
            if (digit_ok) begin
              numero <= chave_s;
              insere <= 1'b1;
            end else begin
              erro   <= 1'b1;
            end
          end else begin
            rcnt <= rcnt + RW'(1);
`endif
          end
        end
        DEB_RELEASE: begin
          if (botao_s) begin
            // release bounce: still the same press, no new strobe
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
